// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - sequential unsigned shift-add multiplier with start/done handshake
module seq_shift_add_multiplier #(
    parameter int Width     = 4,
    parameter int Out_Width = 2 * Width
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [Width-1:0]     A,
    input  logic [Width-1:0]     B,
    output logic [Out_Width-1:0] P,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(Width) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(Width - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [Out_Width-1:0] r_mcand;
    logic [Out_Width-1:0] w_mcand_nxt;
    logic [Out_Width-1:0] r_acc;
    logic [Out_Width-1:0] w_acc_nxt;
    logic [Out_Width-1:0] r_p;
    logic [Out_Width-1:0] w_p_nxt;
    logic [Out_Width-1:0] w_sum;
    logic [Width-1:0]     r_mplier;
    logic [Width-1:0]     w_mplier_nxt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_done;
    logic                 w_done_nxt;

    // Out_Width add cannot overflow: (2^Width-1)^2 < 2^Out_Width.
    assign w_sum = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_comb begin
        w_state_nxt  = r_state;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_p_nxt      = r_p;
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_mcand_nxt  = {{(Out_Width - Width){1'b0}}, A};
                    w_mplier_nxt = B;
                    w_acc_nxt    = '0;
                    w_cnt_nxt    = '0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = CALC;
                end
            end
            CALC: begin
                w_acc_nxt    = w_sum;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_cnt_nxt    = r_cnt + 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_p_nxt     = w_sum;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_p      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_p      <= w_p_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign P    = r_p;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb/tb_seq_shift_add_multiplier.sv - scoreboard bench for seq_shift_add_multiplier
module tb_seq_shift_add_multiplier;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic [7:0] P;
    logic       busy;
    logic       done;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         busy_cycles = 0;
    int         done_cycs[$];
    logic [7:0] exp_q[$];

    seq_shift_add_multiplier #(.Width(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        if (busy) busy_cycles++;
        if (done) begin
            done_cnt++;
            done_cycs.push_back(cyc);
            check("busy_with_done", int'(busy), 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=%0d required=none", P);
            end else begin
                check("product", int'(P), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("idle_timeout", 1, 0);
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input bit push,
                         output int c0);
        wait_idle();
        A     = a;
        B     = b;
        start = 1'b1;
        if (push) exp_q.push_back(8'(a * b));
        @(posedge clk);
        #1;
        c0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0);
        int n;
        n = 0;
        while (done_cnt <= n0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (n >= 40) check("done_timeout", 1, 0);
    endtask

    initial begin
        int c0;
        int n0;
        int q;
        int r;
        int d0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_P", int'(P), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst_n = 1'b1;

        // 5*4: busy for 4 cycles, done exactly 4 cycles after the start edge
        busy_cycles = 0;
        n0 = done_cnt;
        d0 = done_cycs.size();
        issue(4'd5, 4'd4, 1'b1, c0);
        wait_done(n0);
        check("lat_5x4", done_cycs[d0] - c0, 4);
        check("busy_cycles_5x4", busy_cycles, 4);
        check("P_5x4", int'(P), 20);

        // Max value, then zero operand with identical latency
        n0 = done_cnt;
        issue(4'd15, 4'd15, 1'b1, c0);
        wait_done(n0);
        check("P_15x15", int'(P), 225);
        n0 = done_cnt;
        d0 = done_cycs.size();
        issue(4'd0, 4'd7, 1'b1, c0);
        wait_done(n0);
        check("lat_0x7", done_cycs[d0] - c0, 4);
        check("P_0x7", int'(P), 0);

        // start during CALC is ignored; P holds 10 afterwards
        n0 = done_cnt;
        issue(4'd10, 4'd1, 1'b1, c0);
        @(negedge clk);
        A     = 4'd3;
        B     = 4'd3;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(n0);
        repeat (10) @(negedge clk);
        check("P_hold_10", int'(P), 10);

        // start held high: two ops 6 cycles apart, operands resampled
        wait_idle();
        n0 = done_cnt;
        d0 = done_cycs.size();
        A     = 4'd12;
        B     = 4'd13;
        start = 1'b1;
        exp_q.push_back(8'd156);
        exp_q.push_back(8'd15);
        @(posedge clk);
        #1;
        A = 4'd3;
        B = 4'd5;
        repeat (6) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n0 + 1);
        check("b2b_spacing", done_cycs[d0 + 1] - done_cycs[d0], 6);
        check("P_b2b_last", int'(P), 15);

        // Reset mid-CALC discards the operation
        issue(4'd9, 4'd9, 1'b0, c0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_P", int'(P), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        rst_n = 1'b1;
        n0 = done_cnt;
        repeat (12) @(negedge clk);
        check("no_done_after_rst", done_cnt - n0, 0);
        n0 = done_cnt;
        issue(4'd9, 4'd9, 1'b1, c0);
        wait_done(n0);
        check("P_9x9", int'(P), 81);

        // Exhaustive sweep; the scoreboard checks each product
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                n0 = done_cnt;
                issue(4'(a), 4'(b), 1'b1, c0);
                wait_done(n0);
            end
        end

        // Dividend reconstruction: Q*B + R == A
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                q  = a / b;
                r  = a % b;
                n0 = done_cnt;
                issue(4'(q), 4'(b), 1'b1, c0);
                wait_done(n0);
                check("div_xcheck", int'(P) + r, a);
            end
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
